// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// reset_sequencer: holds NUM_CH active-low reset channels low for HOLD_CYCLES
// after reset or a fault, waits for PLL lock, then releases the channels one at
// a time in ascending order, STAGE_CYCLES clocks apart.
// Ports:
//   iTenMHzClk    - sole clock, rising edge
//   iReset        - synchronous active-high reset
//   iPllLocked    - asynchronous PLL lock indication (high = locked)
//   iExtRstReq    - asynchronous external reset request (high = request)
//   oResetn       - per-channel active-low resets, bit 0 released first
//   oAllReleased  - high while every channel is released
//   oRestartCount - saturating count of restarts caused by faults
module reset_sequencer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned HOLD_CYCLES  = 1023,
  parameter int unsigned STAGE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              iTenMHzClk,
  input  logic              iReset,
  input  logic              iPllLocked,
  input  logic              iExtRstReq,
  output logic [NUM_CH-1:0] oResetn,
  output logic              oAllReleased,
  output logic [7:0]        oRestartCount
);

  localparam int unsigned CNT_MAX =
    ((HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES) - 1;
  localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LOAD = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_STAGE,
    ST_RUN
  } state_t;

  // Power-up values match the reset values so sequencing starts without iReset.
  logic [SYNC_STAGES-1:0] lock_sync  = '0;
  logic [SYNC_STAGES-1:0] ext_sync   = '0;
  state_t                 state      = ST_HOLD;
  logic [CNT_W-1:0]       cnt        = HOLD_LOAD;
  logic [IDX_W-1:0]       idx        = '0;
  logic [NUM_CH-1:0]      resetn_q   = '0;
  logic                   all_q      = 1'b0;
  logic [7:0]             restart_q  = 8'd0;

  state_t            state_next;
  logic [CNT_W-1:0]  cnt_next;
  logic [IDX_W-1:0]  idx_next;
  logic [IDX_W-1:0]  idx_plus;
  logic [NUM_CH-1:0] resetn_next;
  logic              all_next;
  logic [7:0]        restart_next;
  logic              lock_s;
  logic              ext_s;
  logic              active;
  logic              fault;
  logic              do_release;
  logic              do_advance;

  assign lock_s   = lock_sync[SYNC_STAGES-1];
  assign ext_s    = ext_sync[SYNC_STAGES-1];
  assign active   = (state == ST_STAGE) || (state == ST_RUN);
  assign fault    = ext_s || (!lock_s && active);
  assign idx_plus = idx + IDX_W'(1);

  assign oResetn       = resetn_q;
  assign oAllReleased  = all_q;
  assign oRestartCount = restart_q;

  // State register, synchronisers and registered outputs.
  always_ff @(posedge iTenMHzClk) begin
    if (iReset) begin
      lock_sync <= '0;
      ext_sync  <= '0;
      state     <= ST_HOLD;
      cnt       <= HOLD_LOAD;
      idx       <= '0;
      resetn_q  <= '0;
      all_q     <= 1'b0;
      restart_q <= 8'd0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], iPllLocked};
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], iExtRstReq};
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      resetn_q  <= resetn_next;
      all_q     <= all_next;
      restart_q <= restart_next;
    end
  end

  // Next-state logic; a fault overrides any sequencing step.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    do_release = 1'b0;
    do_advance = 1'b0;
    if (fault) begin
      state_next = ST_HOLD;
      cnt_next   = HOLD_LOAD;
      idx_next   = '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
          end else if (lock_s) begin
            do_release = 1'b1;
          end else begin
            state_next = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            do_release = 1'b1;
          end
        end
        ST_STAGE: begin
          if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
          end else begin
            do_advance = 1'b1;
            idx_next   = idx_plus;
            cnt_next   = STAGE_LOAD;
            if (idx_plus == LAST_IDX) begin
              state_next = ST_RUN;
            end
          end
        end
        default: begin
        end
      endcase
      if (do_release) begin
        idx_next   = '0;
        cnt_next   = STAGE_LOAD;
        state_next = (NUM_CH == 1) ? ST_RUN : ST_STAGE;
      end
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    resetn_next  = resetn_q;
    all_next     = (state_next == ST_RUN);
    restart_next = restart_q;
    if (fault) begin
      resetn_next = '0;
      // Only a fault that interrupts a released/releasing sequence counts.
      if (active && (restart_q != 8'hFF)) begin
        restart_next = restart_q + 8'd1;
      end
    end else if (do_release) begin
      resetn_next    = '0;
      resetn_next[0] = 1'b1;
    end else if (do_advance) begin
      resetn_next[idx_plus] = 1'b1;
    end
  end

endmodule
